// File: rtl/loopback_rx_pkt_fifo_ctrl_if.sv
// FIFO read port, software control word and readback registers for the loopback RX FIFO controller.
interface loopback_rx_pkt_fifo_ctrl_if;
    logic [31:0] fifo_dout;
    logic        fifo_eof;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] sw_ctrl;
    logic [31:0] rd_data;
    logic [31:0] rd_status;

    // Controller side
    modport slave (
        input  fifo_dout, fifo_eof, fifo_empty, sw_ctrl,
        output fifo_rd_en, rd_data, rd_status
    );

    // FIFO / software side
    modport master (
        output fifo_dout, fifo_eof, fifo_empty, sw_ctrl,
        input  fifo_rd_en, rd_data, rd_status
    );
endinterface

// File: rtl/loopback_rx_pkt_fifo_ctrl.sv
// Software-paced loopback RX FIFO reader: one pop per request toggle, with packet
// tracking, oversize/overrun flags and a flush that drains the FIFO.
module loopback_rx_pkt_fifo_ctrl #(
    parameter int unsigned C_MAX_PKT_WORDS = 256
) (
    input  logic                          OPB_Clk,
    input  logic                          OPB_Rst,
    loopback_rx_pkt_fifo_ctrl_if.slave    bus
);
    localparam int unsigned CNT_W = 16;
    localparam int unsigned PKT_W = 11;
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(C_MAX_PKT_WORDS - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] FLUSH   = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             enable;
    logic             req_bit;
    logic             flush;
    logic             sw_unused;
    logic             tog_prev;
    logic             tog_event;
    logic             pending;
    logic             valid;
    logic             eof_q;
    logic             oversize;
    logic             req_overrun;
    logic             busy;
    logic             in_xfer;
    logic             flush_entry;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] word_idx;
    logic [PKT_W-1:0] pkt_cnt;
    logic [31:0]      rd_data;

    assign enable      = bus.sw_ctrl[0];
    assign req_bit     = bus.sw_ctrl[1];
    assign flush       = bus.sw_ctrl[2];
    assign sw_unused   = ^bus.sw_ctrl[31:3];
    assign tog_event   = req_bit != tog_prev;
    assign in_xfer     = (state == ISSUE) || (state == CAPTURE);
    assign flush_entry = (state == IDLE) && flush;
    assign busy        = pending || (state != IDLE);

    // State register
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next state and pop strobe; pops in FLUSH are gated by empty so the FIFO never underflows
    always_comb begin
        state_nxt      = state;
        bus.fifo_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (flush)                                      state_nxt = FLUSH;
                else if (pending && enable && !bus.fifo_empty)  state_nxt = ISSUE;
            end
            ISSUE: begin
                bus.fifo_rd_en = 1'b1;
                state_nxt      = CAPTURE;
            end
            CAPTURE: state_nxt = IDLE;
            FLUSH: begin
                bus.fifo_rd_en = !bus.fifo_empty;
                if (!flush) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request tracking, capture path and packet counters
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            tog_prev    <= 1'b0;
            pending     <= 1'b0;
            valid       <= 1'b0;
            eof_q       <= 1'b0;
            oversize    <= 1'b0;
            req_overrun <= 1'b0;
            word_cnt    <= '0;
            word_idx    <= '0;
            pkt_cnt     <= '0;
            rd_data     <= '0;
        end else begin
            tog_prev <= req_bit;
            if (flush_entry) begin
                valid       <= 1'b0;
                oversize    <= 1'b0;
                req_overrun <= 1'b0;
                pending     <= 1'b0;
                word_cnt    <= '0;
            end else begin
                // pending/state are sampled pre-edge, so a toggle on the capture edge is an overrun
                if (tog_event && (pending || in_xfer)) req_overrun <= 1'b1;
                if (state == CAPTURE) begin
                    rd_data  <= bus.fifo_dout;
                    valid    <= 1'b1;
                    eof_q    <= bus.fifo_eof;
                    pending  <= 1'b0;
                    word_idx <= word_cnt;
                    if (bus.fifo_eof) begin
                        word_cnt <= '0;
                        pkt_cnt  <= pkt_cnt + PKT_W'(1);
                    end else if (word_cnt == WORD_LAST) begin
                        oversize <= 1'b1;
                        word_cnt <= '0;
                    end else begin
                        word_cnt <= word_cnt + CNT_W'(1);
                    end
                end else if (tog_event && !pending) begin
                    pending <= 1'b1;
                    valid   <= 1'b0;
                end
            end
        end
    end

    assign bus.rd_data   = rd_data;
    assign bus.rd_status = {valid, eof_q, oversize, req_overrun, busy, pkt_cnt, word_idx};
endmodule

// File: tb/tb_loopback_rx_pkt_fifo_ctrl.sv
// Directed bench for loopback_rx_pkt_fifo_ctrl with a behavioural non-FWFT FIFO.
module tb_loopback_rx_pkt_fifo_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic en  = 1'b0;
    logic tog = 1'b0;
    logic fl  = 1'b0;

    logic [32:0] mem [0:255];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;

    always #5 clk = ~clk;

    loopback_rx_pkt_fifo_ctrl_if bus ();

    loopback_rx_pkt_fifo_ctrl #(.C_MAX_PKT_WORDS(4)) dut (
        .OPB_Clk (clk),
        .OPB_Rst (rst),
        .bus     (bus)
    );

    // Standard-mode FIFO: data appears the cycle after a pop
    assign bus.fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (rst) begin
            bus.fifo_dout <= 32'd0;
            bus.fifo_eof  <= 1'b0;
        end
        if (bus.fifo_rd_en && (wr_ptr != rd_ptr)) begin
            bus.fifo_dout <= mem[rd_ptr][31:0];
            bus.fifo_eof  <= mem[rd_ptr][32];
            rd_ptr        <= rd_ptr + 8'd1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive();
        bus.sw_ctrl = {29'd0, fl, tog, en};
    endtask

    task automatic toggle();
        tog = ~tog;
        drive();
    endtask

    task automatic push(input logic [31:0] d, input logic e);
        mem[wr_ptr] = {e, d};
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic test_reset();
        drive();
        rst = 1'b1;
        step(3);
        n_checks++; if (bus.rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h exp %h", bus.rd_data, 32'd0); end
        n_checks++; if (bus.rd_status !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h exp %h", bus.rd_status, 32'd0); end
        n_checks++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b exp 0", bus.fifo_rd_en); end
        rst = 1'b0;
        step(2);
        n_checks++; if (bus.rd_status !== 32'd0) begin n_fail++; $display("FAIL reset_release_status: got %h exp %h", bus.rd_status, 32'd0); end
    endtask

    task automatic test_basic();
        push(32'hA5A50001, 1'b0);
        push(32'hA5A50002, 1'b1);
        en = 1'b1; drive();
        step(1);
        toggle();
        step(1);
        n_checks++; if (bus.rd_status !== 32'h08000000) begin n_fail++; $display("FAIL basic_pending: got %h exp %h", bus.rd_status, 32'h08000000); end
        step(1);
        n_checks++; if (bus.fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL basic_issue_rd_en: got %b exp 1", bus.fifo_rd_en); end
        step(1);
        n_checks++; if (bus.rd_status[31] !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b exp 0", bus.rd_status[31]); end
        step(1);
        n_checks++; if (bus.rd_data !== 32'hA5A50001) begin n_fail++; $display("FAIL basic_data1: got %h exp %h", bus.rd_data, 32'hA5A50001); end
        n_checks++; if (bus.rd_status !== 32'h80000000) begin n_fail++; $display("FAIL basic_status1: got %h exp %h", bus.rd_status, 32'h80000000); end
        step(6);
        toggle();
        step(4);
        n_checks++; if (bus.rd_data !== 32'hA5A50002) begin n_fail++; $display("FAIL basic_data2: got %h exp %h", bus.rd_data, 32'hA5A50002); end
        n_checks++; if (bus.rd_status !== 32'hC0010001) begin n_fail++; $display("FAIL basic_status2: got %h exp %h", bus.rd_status, 32'hC0010001); end
    endtask

    task automatic test_empty_wait();
        int pops = 0;
        toggle();
        step(1);
        n_checks++; if (bus.rd_status !== 32'h48010001) begin n_fail++; $display("FAIL empty_status: got %h exp %h", bus.rd_status, 32'h48010001); end
        for (int i = 0; i < 20; i++) begin
            if (bus.fifo_rd_en === 1'b1) pops++;
            step(1);
        end
        n_checks++; if (pops !== 0) begin n_fail++; $display("FAIL empty_no_pop: got %0d exp 0", pops); end
        push(32'h12345678, 1'b1);
        step(1);
        n_checks++; if (bus.fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL empty_issue: got %b exp 1", bus.fifo_rd_en); end
        step(1);
        n_checks++; if (bus.rd_status[31] !== 1'b0) begin n_fail++; $display("FAIL empty_early_valid: got %b exp 0", bus.rd_status[31]); end
        step(1);
        n_checks++; if (bus.rd_data !== 32'h12345678) begin n_fail++; $display("FAIL empty_data: got %h exp %h", bus.rd_data, 32'h12345678); end
        n_checks++; if (bus.rd_status !== 32'hC0020000) begin n_fail++; $display("FAIL empty_status2: got %h exp %h", bus.rd_status, 32'hC0020000); end
    endtask

    task automatic test_overrun();
        int pops = 0;
        push(32'h00001111, 1'b0);
        push(32'h00002222, 1'b0);
        toggle();
        step(1);
        toggle();
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (bus.fifo_rd_en === 1'b1) pops++;
        end
        n_checks++; if (pops !== 1) begin n_fail++; $display("FAIL overrun_pops: got %0d exp 1", pops); end
        n_checks++; if (bus.rd_data !== 32'h00001111) begin n_fail++; $display("FAIL overrun_data: got %h exp %h", bus.rd_data, 32'h00001111); end
        n_checks++; if (bus.rd_status !== 32'h90020000) begin n_fail++; $display("FAIL overrun_status: got %h exp %h", bus.rd_status, 32'h90020000); end
        n_checks++; if (bus.fifo_empty !== 1'b0) begin n_fail++; $display("FAIL overrun_left_word: got %b exp 0", bus.fifo_empty); end
    endtask

    task automatic test_flush();
        int pops = 0;
        int bad  = 0;
        for (int i = 0; i < 100; i++) push(32'(i), (i % 10) == 9);
        fl = 1'b1; drive();
        step(1);
        n_checks++; if (bus.rd_status !== 32'h08020000) begin n_fail++; $display("FAIL flush_entry_status: got %h exp %h", bus.rd_status, 32'h08020000); end
        for (int i = 0; i < 120; i++) begin
            if (bus.fifo_rd_en === 1'b1) pops++;
            if (bus.fifo_rd_en === 1'b1 && bus.fifo_empty === 1'b1) bad++;
            step(1);
        end
        n_checks++; if (pops !== 101) begin n_fail++; $display("FAIL flush_pops: got %0d exp 101", pops); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL flush_pop_when_empty: got %0d exp 0", bad); end
        n_checks++; if (bus.fifo_empty !== 1'b1) begin n_fail++; $display("FAIL flush_drained: got %b exp 1", bus.fifo_empty); end
        n_checks++; if (bus.rd_data !== 32'h00001111) begin n_fail++; $display("FAIL flush_data_held: got %h exp %h", bus.rd_data, 32'h00001111); end
        fl = 1'b0; drive();
        step(2);
        n_checks++; if (bus.rd_status !== 32'h00020000) begin n_fail++; $display("FAIL flush_exit_status: got %h exp %h", bus.rd_status, 32'h00020000); end
    endtask

    task automatic test_oversize();
        logic [31:0] exp_st [0:4];
        exp_st[0] = 32'h80020000;
        exp_st[1] = 32'h80020001;
        exp_st[2] = 32'h80020002;
        exp_st[3] = 32'hA0020003;
        exp_st[4] = 32'hA0020000;
        for (int i = 0; i < 5; i++) push(32'h50 + 32'(i), 1'b0);
        for (int i = 0; i < 5; i++) begin
            toggle();
            step(4);
            n_checks++; if (bus.rd_data !== 32'h50 + 32'(i)) begin n_fail++; $display("FAIL oversize_data%0d: got %h exp %h", i, bus.rd_data, 32'h50 + 32'(i)); end
            n_checks++; if (bus.rd_status !== exp_st[i]) begin n_fail++; $display("FAIL oversize_status%0d: got %h exp %h", i, bus.rd_status, exp_st[i]); end
        end
    endtask

    task automatic test_enable();
        int pops = 0;
        push(32'h00000077, 1'b1);
        en = 1'b0;
        toggle();
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (bus.fifo_rd_en === 1'b1) pops++;
        end
        n_checks++; if (pops !== 0) begin n_fail++; $display("FAIL enable_blocked: got %0d exp 0", pops); end
        n_checks++; if (bus.rd_status[27] !== 1'b1) begin n_fail++; $display("FAIL enable_busy: got %b exp 1", bus.rd_status[27]); end
        en = 1'b1; drive();
        step(3);
        n_checks++; if (bus.rd_data !== 32'h00000077) begin n_fail++; $display("FAIL enable_data: got %h exp %h", bus.rd_data, 32'h00000077); end
        n_checks++; if (bus.rd_status !== 32'hE0030001) begin n_fail++; $display("FAIL enable_status: got %h exp %h", bus.rd_status, 32'hE0030001); end
    endtask

    task automatic test_reset_mid();
        push(32'h00000099, 1'b0);
        toggle();
        step(3);
        n_checks++; if (bus.rd_status[27] !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: got %b exp 1", bus.rd_status[27]); end
        rst = 1'b1;
        en = 1'b0; tog = 1'b0; fl = 1'b0; drive();
        #1;
        n_checks++; if (bus.rd_data !== 32'd0) begin n_fail++; $display("FAIL rstmid_data: got %h exp %h", bus.rd_data, 32'd0); end
        n_checks++; if (bus.rd_status !== 32'd0) begin n_fail++; $display("FAIL rstmid_status: got %h exp %h", bus.rd_status, 32'd0); end
        n_checks++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd_en: got %b exp 0", bus.fifo_rd_en); end
        @(negedge clk);
        rst = 1'b0;
        step(2);
        n_checks++; if (bus.rd_status !== 32'd0) begin n_fail++; $display("FAIL rstmid_idle: got %h exp %h", bus.rd_status, 32'd0); end
        n_checks++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle_rd_en: got %b exp 0", bus.fifo_rd_en); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty_wait();
        test_overrun();
        test_flush();
        test_oversize();
        test_enable();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
